// File: rtl/multi_led_ctrl.sv
// multi_led_ctrl: N-channel front-panel LED driver.
//   A shared free-running slow/fast blink generator keeps every blinking
//   channel phase-aligned. Each channel has a 2-bit mode and a fault
//   override that forces fast blink. A timed lamp test lights all channels.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   i_mode      in   per-channel mode, ch i at [2i+1:2i]
//                    00 ON, 01 OFF, 10 BLINK_SLOW, 11 BLINK_FAST
//   i_fault     in   per-channel fault; 1 forces fast blink on that channel
//   i_lamp_test in   lamp-test request, rising-edge triggered
//   o_led       out  registered LED drive, polarity set by LED_ACTIVE_LOW
//   o_lamp_busy out  high while the lamp test is running
module multi_led_ctrl #(
  parameter int unsigned CH_NUM         = 8,
  parameter int unsigned SLOW_HALF_CYC  = 12_500_000,
  parameter int unsigned FAST_HALF_CYC  = 3_125_000,
  parameter int unsigned LAMP_TEST_CYC  = 50_000_000,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*CH_NUM-1:0]   i_mode,
  input  logic [CH_NUM-1:0]     i_fault,
  input  logic                  i_lamp_test,
  output logic [CH_NUM-1:0]     o_led,
  output logic                  o_lamp_busy
);

  localparam int unsigned SW = (SLOW_HALF_CYC > 1) ? $clog2(SLOW_HALF_CYC) : 1;
  localparam int unsigned FW = (FAST_HALF_CYC > 1) ? $clog2(FAST_HALF_CYC) : 1;
  localparam int unsigned LW = (LAMP_TEST_CYC > 1) ? $clog2(LAMP_TEST_CYC) : 1;

  localparam logic [SW-1:0] S_LAST = SW'(SLOW_HALF_CYC - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FAST_HALF_CYC - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LAMP_TEST_CYC - 1);

  localparam logic [CH_NUM-1:0] LED_DARK = {CH_NUM{LED_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    MODE_ON   = 2'b00,
    MODE_OFF  = 2'b01,
    MODE_SLOW = 2'b10,
    MODE_FAST = 2'b11
  } led_mode_e;

  typedef enum logic {
    LAMP_IDLE,
    LAMP_TEST
  } lamp_state_e;

  logic [SW-1:0]     cnt_s_q, cnt_s_d;
  logic [FW-1:0]     cnt_f_q, cnt_f_d;
  logic              slow_ph_q, slow_ph_d;
  logic              fast_ph_q, fast_ph_d;
  lamp_state_e       lamp_state_q, lamp_state_d;
  logic [LW-1:0]     lamp_cnt_q, lamp_cnt_d;
  logic              lamp_req_q, lamp_req_d;
  logic [CH_NUM-1:0] led_q, led_d;
  logic              lamp_on;
  logic [CH_NUM-1:0] lit;
  led_mode_e         ch_mode;

  // Blink prescalers
  always_comb begin
    cnt_s_d   = cnt_s_q + SW'(1);
    slow_ph_d = slow_ph_q;
    if (cnt_s_q == S_LAST) begin
      cnt_s_d   = '0;
      slow_ph_d = ~slow_ph_q;
    end

    cnt_f_d   = cnt_f_q + FW'(1);
    fast_ph_d = fast_ph_q;
    if (cnt_f_q == F_LAST) begin
      cnt_f_d   = '0;
      fast_ph_d = ~fast_ph_q;
    end
  end

  // Lamp-test FSM
  always_comb begin
    lamp_state_d = lamp_state_q;
    lamp_cnt_d   = lamp_cnt_q;
    lamp_req_d   = i_lamp_test;
    unique case (lamp_state_q)
      LAMP_IDLE: begin
        if (i_lamp_test && !lamp_req_q) begin
          lamp_state_d = LAMP_TEST;
          lamp_cnt_d   = L_LAST;
        end
      end
      LAMP_TEST: begin
        if (lamp_cnt_q == '0) begin
          lamp_state_d = LAMP_IDLE;
        end else begin
          lamp_cnt_d = lamp_cnt_q - LW'(1);
        end
      end
      default: lamp_state_d = LAMP_IDLE;
    endcase
  end

  // Lamp override follows the next FSM state so the LEDs light in the same
  // cycle o_lamp_busy rises and go dark in the cycle it falls.
  assign lamp_on = (lamp_state_d == LAMP_TEST);

  // Per-channel lit decision, priority: lamp > fault > mode
  always_comb begin
    lit     = '0;
    ch_mode = MODE_OFF;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      ch_mode = led_mode_e'(i_mode[2*i +: 2]);
      if (lamp_on) begin
        lit[i] = 1'b1;
      end else if (i_fault[i]) begin
        lit[i] = fast_ph_q;
      end else begin
        unique case (ch_mode)
          MODE_ON:   lit[i] = 1'b1;
          MODE_OFF:  lit[i] = 1'b0;
          MODE_SLOW: lit[i] = slow_ph_q;
          MODE_FAST: lit[i] = fast_ph_q;
          default:   lit[i] = 1'b0;
        endcase
      end
    end
    led_d = lit ^ LED_DARK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_s_q      <= '0;
      cnt_f_q      <= '0;
      slow_ph_q    <= 1'b0;
      fast_ph_q    <= 1'b0;
      lamp_state_q <= LAMP_IDLE;
      lamp_cnt_q   <= '0;
      lamp_req_q   <= 1'b0;
      led_q        <= LED_DARK;
    end else begin
      cnt_s_q      <= cnt_s_d;
      cnt_f_q      <= cnt_f_d;
      slow_ph_q    <= slow_ph_d;
      fast_ph_q    <= fast_ph_d;
      lamp_state_q <= lamp_state_d;
      lamp_cnt_q   <= lamp_cnt_d;
      lamp_req_q   <= lamp_req_d;
      led_q        <= led_d;
    end
  end

  assign o_led       = led_q;
  assign o_lamp_busy = (lamp_state_q == LAMP_TEST);

endmodule

// File: tb/tb_multi_led_ctrl.sv
module tb_multi_led_ctrl;

  localparam int unsigned CH   = 4;
  localparam int unsigned SH   = 8;
  localparam int unsigned FH   = 2;
  localparam int unsigned LAMP = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    i_mode = 8'h55;
  logic [3:0]    i_fault = '0;
  logic          i_lamp_test = 1'b0;
  logic [3:0]    led_lo, led_hi;
  logic          busy_lo, busy_hi;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  int unsigned k        = 0;  // clock edges since the last reset
  int unsigned lamp_rem = 0;  // lit cycles still owed to the lamp test
  bit          prev_req = 1'b0;

  always #5 clk = ~clk;

  multi_led_ctrl #(
    .CH_NUM(CH), .SLOW_HALF_CYC(SH), .FAST_HALF_CYC(FH),
    .LAMP_TEST_CYC(LAMP), .LED_ACTIVE_LOW(1'b1)
  ) dut_lo (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_fault(i_fault),
    .i_lamp_test(i_lamp_test), .o_led(led_lo), .o_lamp_busy(busy_lo)
  );

  multi_led_ctrl #(
    .CH_NUM(CH), .SLOW_HALF_CYC(SH), .FAST_HALF_CYC(FH),
    .LAMP_TEST_CYC(LAMP), .LED_ACTIVE_LOW(1'b0)
  ) dut_hi (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_fault(i_fault),
    .i_lamp_test(i_lamp_test), .o_led(led_hi), .o_lamp_busy(busy_hi)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp_v);
    end
  endtask

  // Apply inputs for one cycle, advance the model, check both polarities.
  task automatic step(input bit r, input logic [7:0] m, input logic [3:0] f, input bit lt);
    logic [3:0] exp_lit;
    bit         exp_busy;
    bit         ph_s, ph_f;
    @(negedge clk);
    rst = r; i_mode = m; i_fault = f; i_lamp_test = lt;
    @(posedge clk);
    #1;
    if (r) begin
      k = 0; lamp_rem = 0; prev_req = 1'b0;
      exp_lit = '0; exp_busy = 1'b0;
    end else begin
      ph_s = ((k / SH) % 2) == 1;
      ph_f = ((k / FH) % 2) == 1;
      if (lamp_rem > 0) lamp_rem--;
      else if (lt && !prev_req) lamp_rem = LAMP;
      prev_req = lt;
      exp_busy = (lamp_rem > 0);
      for (int c = 0; c < 4; c++) begin
        if (exp_busy)  exp_lit[c] = 1'b1;
        else if (f[c]) exp_lit[c] = ph_f;
        else case (m[2*c +: 2])
          2'b00:   exp_lit[c] = 1'b1;
          2'b01:   exp_lit[c] = 1'b0;
          2'b10:   exp_lit[c] = ph_s;
          default: exp_lit[c] = ph_f;
        endcase
      end
      k++;
    end
    check_eq("led_active_low",  {28'd0, led_lo}, {28'd0, ~exp_lit});
    check_eq("led_active_high", {28'd0, led_hi}, {28'd0, exp_lit});
    check_eq("lamp_busy",       {31'd0, busy_lo}, {31'd0, exp_busy});
    check_eq("lamp_busy_hi",    {31'd0, busy_hi}, {31'd0, exp_busy});
  endtask

  initial begin
    logic [7:0] m;
    logic [3:0] f;
    bit         lt;

    // Reset with all channels OFF, then hold
    repeat (2) step(1'b1, 8'h55, 4'h0, 1'b0);
    repeat (4) step(1'b0, 8'h55, 4'h0, 1'b0);

    // Mixed modes {FAST,SLOW,OFF,ON} straight out of reset
    step(1'b1, 8'hE4, 4'h0, 1'b0);
    repeat (34) step(1'b0, 8'hE4, 4'h0, 1'b0);

    // Fault override on an ON channel, alongside a fast-blink channel
    repeat (6) step(1'b0, 8'hC0, 4'h1, 1'b0);
    repeat (3) step(1'b0, 8'hC0, 4'h0, 1'b0);

    // Lamp test pulse, retrigger attempt mid-test, then held-high request
    step(1'b0, 8'hE4, 4'h0, 1'b1);
    repeat (2) step(1'b0, 8'hE4, 4'h0, 1'b0);
    step(1'b0, 8'hE4, 4'h0, 1'b1);
    repeat (6) step(1'b0, 8'hE4, 4'h0, 1'b0);
    repeat (10) step(1'b0, 8'hE4, 4'h0, 1'b1);
    repeat (2) step(1'b0, 8'hE4, 4'h0, 1'b0);

    // Reset in the third lamp-test cycle, then phases restart
    step(1'b0, 8'hE4, 4'h0, 1'b1);
    repeat (2) step(1'b0, 8'hE4, 4'h0, 1'b0);
    step(1'b1, 8'hE4, 4'h0, 1'b0);
    repeat (20) step(1'b0, 8'hE4, 4'h0, 1'b0);

    // Request already high on the first cycle after reset
    step(1'b1, 8'h55, 4'h0, 1'b1);
    repeat (8) step(1'b0, 8'h55, 4'h0, 1'b1);

    // Randomized traffic
    m = 8'hE4; f = '0; lt = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(15) == 0) m = 8'($urandom);
      if ($urandom_range(31) == 0) f = 4'($urandom & $urandom);
      if ($urandom_range(9) == 0)  lt = ~lt;
      step($urandom_range(199) == 0, m, f, lt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
